uart_tx_fifo: RTL

Serial transmit stage downstream of the CPU inside `computer`. It accepts bytes from the CPU's memory-mapped I/O write strobe into a small FIFO and serializes each one as an 8N1 frame on `txd`. It is the first off-chip output path of the system, and the top-level bench uses it to watch program output.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo_if.sv | 16 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Transmit FSM states, also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port of the UART transmit stage.
//
// Handshake: wr_en qualifies wr_data for exactly the cycle it is high; the
// byte is taken on that rising edge if full was 0 before the edge. There is
// no back-pressure stall: a write presented while full=1 is dropped and
// latches ovf until reset. busy and full are register-driven.
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       ovf;

  modport master (output wr_en, wr_data, input full, busy, ovf);
  modport slave  (input wr_en, wr_data, output full, busy, ovf);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head data is visible combinationally on dout.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_nxt;
  logic          push_ok;
  logic          pop_ok;

  // A push is judged against the registered full flag, so a pop in the same
  // cycle never frees a slot for it.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) count_nxt = count + (AW+1)'(1);
    if (!push_ok && pop_ok) count_nxt = count - (AW+1)'(1);
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter: FIFO in front of a bit-timed shift FSM.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic                   clock_50_b7a,
  input  logic                   reset,
  uart_tx_fifo_if.slave          bus,
  output logic                   txd,
  output tx_state_t              dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

  tx_state_t              state;
  logic [DW-1:0]          div;
  logic [2:0]             bit_idx;
  logic [7:0]             sh;
  logic                   ovf_q;
  logic                   tick;
  logic                   pop;
  logic [7:0]             head;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  // A bit boundary is the cycle the divider has counted down to zero. The
  // head is taken either from idle or right at the end of a stop bit, so
  // back-to-back frames have no idle gap.
  assign tick = (div == '0);
  assign pop  = !empty && ((state == IDLE) || (state == STOP && tick));

  sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clock_50_b7a),
    .rst_n (reset),
    .push  (bus.wr_en),
    .din   (bus.wr_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.full  = full;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state != IDLE) || !empty;
  assign dbg_state = state;
  assign dbg_count = count;

  // Frame FSM: divider, shift register, registered txd and sticky overflow.
  always_ff @(posedge clock_50_b7a) begin
    if (!reset) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      txd     <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.wr_en && full) ovf_q <= 1'b1;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            sh    <= head;
            div   <= DIV_M1;
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            div     <= DIV_M1;
            txd     <= sh[0];
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            div <= div - DW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            div <= DIV_M1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= sh[1];
              sh      <= {1'b0, sh[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            div <= div - DW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            if (!empty) begin
              sh    <= head;
              div   <= DIV_M1;
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            div <= div - DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
